bus_req_queue: RTL and testbench
================================

Name: bus_req_queue

Overview:
- Per-core outbound buffer between a processing core and the two-requester bus arbiter.
- The core pushes 32-bit words into a small FIFO.
- The block presents the head word plus a request line to the arbiter, pops the head on grant, and flags starvation when a request stays ungranted too long.
- One instance per core: core A's instance drives the arbiter's A side, core B's drives the B side.

Parameters:
- DATA_W, 32, width of each queued word and of bus_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- WAIT_LIMIT, 15, consecutive ungranted request cycles before starve asserts; range 1..255.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  core push strobe.
- wr_data  input  DATA_W  word to push.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  log2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: push attempted while full.
- bus_req  output  1  request to arbiter.
- bus_data  output  DATA_W  head word presented to arbiter.
- bus_grant  input  1  grant from arbiter, combinational in the same cycle.
- starve  output  1  request pending >= WAIT_LIMIT cycles without grant.

Behaviour:
- Reset (rst high at a rising edge): count=0, rd/wr pointers=0, overflow=0, wait counter=0, state=IDLE. Outputs after reset: empty=1, full=0, bus_req=0, bus_data=0, starve=0. rst dominates all other inputs in that cycle; in-flight words are discarded.
- Storage: circular buffer; pointers wrap modulo DEPTH. count tracks occupancy independently of the pointers.
- Push: wr_en=1 and full=0 writes wr_data at wr_ptr at the edge; wr_ptr++.
- Push while full: wr_en=1 and full=1 discards the word and sets overflow to 1, cleared only by rst. This holds even if a pop occurs in the same cycle; full is evaluated before the edge.
- Pop: bus_req=1 and bus_grant=1 at an edge; rd_ptr++.
- bus_grant while bus_req=0 is ignored.
- Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- Push into an empty FIFO: the word appears on bus_data, and bus_req rises, one cycle after the push edge. There is no same-cycle bypass.
- bus_req = !empty (registered-state derived, no combinational path from bus_grant).
- bus_data = mem[rd_ptr] when !empty, else all zeros.
- Throughput: one word per cycle under continuous grant.
- FSM (states: IDLE, REQ, STARVED):
  - IDLE: empty. Moves to REQ when count becomes nonzero.
  - REQ: bus_req=1. Each ungranted cycle increments the wait counter. Counter reaching WAIT_LIMIT moves to STARVED.
  - STARVED: bus_req=1, starve=1.
  - From REQ or STARVED: a grant clears the wait counter; next state is REQ if words remain after the pop, else IDLE.
- Wait counter: 8 bits, saturates at WAIT_LIMIT, never wraps.
- starve is high exactly in STARVED.
- Ports full, empty and count are all derived from count.

Test Plan:
- Reset mid-operation: push 3 words, assert rst one cycle -> count=0, empty=1, bus_req=0, bus_data=0, overflow=0, starve=0.
- Ordering: push 0xA1, 0xA2, 0xA3, then hold bus_grant=1 -> bus_data shows 0xA1, 0xA2, 0xA3 on consecutive cycles, then empty=1, bus_req=0, bus_data=0.
- Overflow and wrap-around (DEPTH=4):
  - Push 4 words -> full=1, count=4.
  - A 5th push 0xFF -> overflow=1, count stays 4.
  - Pop 2, push 2 more -> output order preserved across pointer wrap; 0xFF never appears.
- Simultaneous push/pop at count=2: wr_en=1 with bus_grant=1 -> count stays 2, head advances, pushed word appears at the tail.
- Starvation (WAIT_LIMIT=15): push 1 word, hold bus_grant=0 -> starve rises after the 15th ungranted cycle and stays high. A single-cycle grant pops the word, starve=0 the next cycle, state=IDLE.
- Back-to-back with grant toggling every other cycle over 6 words -> exactly 6 pops, wait counter never reaches the limit, starve stays 0.

Source files
------------

// File: rtl/bus_req_queue.sv
// bus_req_queue: per-core outbound word FIFO feeding one side of the bus arbiter.
// Presents the head word with a request, pops on grant, and flags starvation
// after WAIT_LIMIT consecutive ungranted request cycles.
module bus_req_queue #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     bus_req,
  output logic [DATA_W-1:0]        bus_data,
  input  logic                     bus_grant,
  output logic                     starve
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [7:0]  LIMIT = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STARVED
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        wait_q, wait_inc;
  state_e            state_q;

  logic push, pop;

  // Status and arbiter-facing outputs, derived only from registered state.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    overflow = overflow_q;
    bus_req  = !empty;
    bus_data = empty ? '0 : mem_q[rd_ptr_q];
    starve   = (state_q == STARVED);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    push       = wr_en && !full;
    pop        = bus_req && bus_grant;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    // A push while full is dropped even when a pop frees a slot this cycle.
    overflow_d = overflow_q || (wr_en && full);
    wait_inc   = (wait_q < LIMIT) ? wait_q + 8'd1 : wait_q;
  end

  // Pointer, occupancy and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Request FSM with saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (count_d != '0) begin
            state_q <= REQ;
          end
        end
        REQ, STARVED: begin
          if (pop) begin
            wait_q  <= '0;
            state_q <= (count_d != '0) ? REQ : IDLE;
          end else begin
            wait_q  <= wait_inc;
            state_q <= (wait_inc == LIMIT) ? STARVED : REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_req_queue.sv
// Self-checking bench for bus_req_queue: queue-based reference model, a
// per-cycle compare process, directed scenarios with literal expectations,
// and a randomized phase with varying grant density.
module tb_bus_req_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 15;

  logic          clk = 1'b0;
  logic          rst, wr_en, bus_grant;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, bus_req, starve;
  logic [2:0]    count;
  logic [DW-1:0] bus_data;

  always #5 clk = ~clk;

  bus_req_queue #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .WAIT_LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .bus_req   (bus_req),
    .bus_data  (bus_data),
    .bus_grant (bus_grant),
    .starve    (starve)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: word queue, sticky overflow, ungranted-cycle counter.
  logic [DW-1:0] mq[$];
  bit            m_ovf  = 0;
  int            m_wait = 0;
  bit            chk_en = 0;
  int            dut_pops = 0;
  bit            starve_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",    32'(count),    32'(mq.size()));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("full",     32'(full),     32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("bus_req",  32'(bus_req),  32'(mq.size() != 0));
      chk("bus_data", bus_data,      (mq.size() != 0) ? mq[0] : 32'h0);
      chk("starve",   32'(starve),   32'(mq.size() != 0 && m_wait >= LIM));
      if (starve) starve_seen = 1;
    end
  end

  // Apply one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit g);
    bit was_full, was_nonempty;
    rst = r; wr_en = w; wr_data = d; bus_grant = g;
    if (!r && bus_req && g) dut_pops++;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf  = 0;
      m_wait = 0;
    end else begin
      was_full     = (mq.size() == DEPTH);
      was_nonempty = (mq.size() != 0);
      if (w && was_full) m_ovf = 1;
      if (g && was_nonempty) begin
        void'(mq.pop_front());
        m_wait = 0;
      end else if (was_nonempty) begin
        m_wait = (m_wait < LIM) ? m_wait + 1 : m_wait;
      end
      if (w && !was_full) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  int pcts[8] = '{0, 30, 70, 100, 0, 50, 90, 10};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; bus_grant = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0);
    chk_en = 1;

    // Reset state, then reset in the middle of activity.
    chk("rst0_empty", 32'(empty), 1);
    chk("rst0_req",   32'(bus_req), 0);
    step(0, 1, 32'h11, 0);
    step(0, 1, 32'h12, 0);
    step(0, 1, 32'h13, 0);
    chk("pre_rst_count", 32'(count), 3);
    step(1, 1, 32'h14, 1);
    chk("rst_count",    32'(count), 0);
    chk("rst_empty",    32'(empty), 1);
    chk("rst_req",      32'(bus_req), 0);
    chk("rst_data",     bus_data, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_starve",   32'(starve), 0);

    // Ordering under continuous grant.
    step(0, 1, 32'hA1, 0);
    chk("order_first_data", bus_data, 32'hA1);
    step(0, 1, 32'hA2, 0);
    step(0, 1, 32'hA3, 0);
    chk("order_head", bus_data, 32'hA1);
    step(0, 0, 0, 1);
    chk("order_2", bus_data, 32'hA2);
    step(0, 0, 0, 1);
    chk("order_3", bus_data, 32'hA3);
    step(0, 0, 0, 1);
    chk("order_empty", 32'(empty), 1);
    chk("order_data0", bus_data, 0);

    // Fill, overflow, then wrap-around.
    for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + 32'(i), 0);
    chk("fill_full",  32'(full), 1);
    chk("fill_count", 32'(count), 4);
    step(0, 1, 32'hFF, 0);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h14, 0);
    step(0, 1, 32'h15, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order", bus_data, 32'h12 + 32'(i));
      step(0, 0, 0, 1);
    end
    chk("wrap_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    step(1, 0, 0, 0);

    // Simultaneous push and pop at count 2.
    step(0, 1, 32'h21, 0);
    step(0, 1, 32'h22, 0);
    step(0, 1, 32'h23, 1);
    chk("sim_count", 32'(count), 2);
    chk("sim_head",  bus_data, 32'h22);
    step(0, 0, 0, 1);
    chk("sim_tail",  bus_data, 32'h23);
    step(0, 0, 0, 1);

    // Starvation timing and recovery.
    step(0, 1, 32'h31, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0);
    chk("starve_14", 32'(starve), 0);
    step(0, 0, 0, 0);
    chk("starve_15", 32'(starve), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("starve_hold", 32'(starve), 1);
    step(0, 0, 0, 1);
    chk("starve_clear", 32'(starve), 0);
    chk("starve_empty", 32'(empty), 1);

    // Back-to-back with alternating grant over six words.
    dut_pops = 0;
    starve_seen = 0;
    for (int i = 0; i < 16; i++) step(0, i < 6, 32'h40 + 32'(i), i[0]);
    chk("b2b_pops",   32'(dut_pops), 6);
    chk("b2b_starve", 32'(starve_seen), 0);
    chk("b2b_empty",  32'(empty), 1);

    // Randomized traffic with varying grant density.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 99) < pcts[b]);
      end
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
